// File: rtl/spi_adc_scanner.sv
// Round-robin SPI (mode 0) master for a multi-channel SAR ADC.
// Each converted sample is returned with its channel tag on a valid/ready stream.
module spi_adc_scanner #(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int SCK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              single_ended,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              cs_n,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic              busy
);

  // state | meaning
  // IDLE  | cs_n high, waiting for en and a non-empty channel mask
  // SETUP | cs_n low, sck low for SCK_DIV clks before the first bit
  // SHIFT | FRAME_BITS sck periods, low half then high half
  // HOLD  | one clk after the last falling sck edge
  // GAP   | cs_n high for GAP_CYC clks between frames

  localparam int FRAME_BITS = 3 + CH_W + DATA_W;
  localparam int CNT_MAX    = (SCK_DIV > GAP_CYC) ? SCK_DIV : GAP_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] SCK_LOAD = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] cmd_sr;
  logic [FRAME_BITS-1:0] cmd_word;
  logic [DATA_W-1:0]     rx_sr;
  logic [CH_W-1:0]       ch_cur;
  logic                  ptr_none;
  logic [CH_W-1:0]       pick_ch;
  logic                  pick_hit;
  logic                  go;
  logic                  frame_start, setup_end, sck_rise, sck_fall, hold_end;
  logic                  last_fall;
  logic                  xfer;

  assign go        = en & (|ch_mask);
  assign last_fall = sck_fall & (bit_cnt == LAST_BIT);
  assign xfer      = o_valid & o_ready;
  assign busy      = (state != S_IDLE);
  assign cmd_word  = {1'b1, single_ended, pick_ch, {(DATA_W + 1){1'b0}}};

  // Next enabled channel above the last one used, else wrap to the lowest enabled.
  always_comb begin
    pick_ch  = '0;
    pick_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i] && (ptr_none || i > int'(ch_cur))) begin
        pick_ch  = CH_W'(i);
        pick_hit = 1'b1;
      end
    end
    if (!pick_hit) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_mask[i]) pick_ch = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    setup_end   = 1'b0;
    sck_rise    = 1'b0;
    sck_fall    = 1'b0;
    hold_end    = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          frame_start = 1'b1;
          state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          setup_end = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          if (!sck) begin
            sck_rise = 1'b1;
          end else begin
            sck_fall = 1'b1;
            if (bit_cnt == LAST_BIT) state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        hold_end  = 1'b1;
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (cnt == '0) begin
          if (go) begin
            frame_start = 1'b1;
            state_nxt   = S_SETUP;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      cmd_sr   <= '0;
      rx_sr    <= '0;
      ch_cur   <= '0;
      ptr_none <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      if (frame_start || setup_end || sck_rise || (sck_fall && !last_fall))
        cnt <= SCK_LOAD;
      else if (hold_end)
        cnt <= GAP_LOAD;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;

      if (frame_start) begin
        ch_cur   <= pick_ch;
        ptr_none <= 1'b0;
        cmd_sr   <= cmd_word;
        mosi     <= 1'b1;
        cs_n     <= 1'b0;
      end

      if (setup_end) begin
        bit_cnt <= '0;
        mosi    <= cmd_sr[FRAME_BITS-1];
      end

      if (sck_rise) sck <= 1'b1;

      // Falling sck edge: capture miso and present the next command bit.
      if (sck_fall) begin
        sck   <= 1'b0;
        rx_sr <= {rx_sr[DATA_W-2:0], miso};
        if (last_fall) begin
          mosi <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          cmd_sr  <= {cmd_sr[FRAME_BITS-2:0], 1'b0};
          mosi    <= cmd_sr[FRAME_BITS-2];
        end
      end

      if (hold_end) cs_n <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data  <= '0;
      o_ch    <= '0;
      o_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (hold_end) begin
        o_data  <= rx_sr;
        o_ch    <= ch_cur;
        o_valid <= 1'b1;
      end else if (xfer) begin
        o_valid <= 1'b0;
      end

      if (hold_end && o_valid && !o_ready) overrun <= 1'b1;
      else if (clr_overrun)                overrun <= 1'b0;
    end
  end

endmodule
